seq_track: RTL and testbench



---
 rtl/seq_track_pkg.sv | 36 +++
 rtl/seq_track_lut.sv | 18 +
 rtl/seq_track.sv | 140 ++++++++++++++
 tb/tb_seq_track.sv | 175 +++++++++++++++++
 4 files changed

// File: rtl/seq_track_pkg.sv
// rtl/seq_track_pkg.sv - constants, FSM type and raw/index tables for seq_track
package seq_track_pkg;

  localparam int         SEQ_LEN      = 10;
  localparam logic [3:0] RESET_STATE  = 4'd10;
  localparam logic [15:0] ILLEGAL_MASK = 16'hB0C2;

  typedef enum logic [1:0] {
    HUNT    = 2'd0,
    CONFIRM = 2'd1,
    LOCKED  = 2'd2
  } seqState_t;

  // One nibble per raw code (raw 15 in the top nibble); illegal codes map to 0
  localparam logic [63:0] RAW_TO_IDX = 64'h0500_2063_0094_8107;
  // One nibble per index (index 15 in the top nibble); only 0..9 are used
  localparam logic [63:0] IDX_TO_RAW = 64'h0000_0053_09E4_8B2A;

  function automatic logic [3:0] rawToIdx(input logic [3:0] raw);
    return RAW_TO_IDX[{raw, 2'b00} +: 4];
  endfunction

  function automatic logic [3:0] idxToRaw(input logic [3:0] index);
    return IDX_TO_RAW[{index, 2'b00} +: 4];
  endfunction

  // Raw code that follows raw in the cycle; index 9 wraps back to index 0
  function automatic logic [3:0] nextRaw(input logic [3:0] raw);
    logic [3:0] cur;
    logic [3:0] nxt;
    cur = rawToIdx(raw);
    nxt = (cur == 4'(SEQ_LEN - 1)) ? 4'd0 : cur + 4'd1;
    return idxToRaw(nxt);
  endfunction

endpackage

// File: rtl/seq_track_lut.sv
// rtl/seq_track_lut.sv - combinational raw state decode: legal flag, index, successor
module seq_track_lut
  import seq_track_pkg::*;
(
  input  logic [3:0] rawState,
  output logic       legal,
  output logic [3:0] index,
  output logic [3:0] nextState
);

  // Pure table lookup; index/nextState are meaningless when legal is low
  always_comb begin
    legal     = ~ILLEGAL_MASK[rawState];
    index     = rawToIdx(rawState);
    nextState = nextRaw(rawState);
  end

endmodule

// File: rtl/seq_track.sv
// rtl/seq_track.sv - lock/track FSM for the 10-state raw counter stream; SEQ_TRACK_ERRCNT_EN adds err_cnt
module seq_track
  import seq_track_pkg::*;
#(
  parameter int LOCK_CNT = 3,
  parameter int LOSS_CNT = 2
) (
  input  logic       C,
  input  logic       nR,
  input  logic       in_valid,
  input  logic [3:0] in_state,
  output logic [3:0] expected,
  output logic [3:0] idx,
  output logic       idx_valid,
  output logic       locked,
  output logic       err,
`ifdef SEQ_TRACK_ERRCNT_EN
  output logic [7:0] err_cnt,
`endif
  output logic       illegal
);

  localparam logic [1:0] StHunt    = HUNT;
  localparam logic [1:0] StConfirm = CONFIRM;
  localparam logic [1:0] StLocked  = LOCKED;

  localparam logic [2:0] LockTarget = 3'(LOCK_CNT);
  localparam logic [2:0] LossTarget = 3'(LOSS_CNT);

  logic [1:0] state;
  logic [2:0] matchCnt;
  logic [2:0] missCnt;
  logic       sLegal;
  logic [3:0] sIdx;
  logic [3:0] sNext;

  seq_track_lut lut (
    .rawState (in_state),
    .legal    (sLegal),
    .index    (sIdx),
    .nextState(sNext)
  );

  // Tracker FSM: seed in HUNT, count matches in CONFIRM, flywheel through misses in LOCKED
  always_ff @(posedge C or negedge nR) begin
    if (!nR) begin
      state     <= StHunt;
      expected  <= RESET_STATE;
      idx       <= 4'd0;
      idx_valid <= 1'b0;
      locked    <= 1'b0;
      err       <= 1'b0;
      illegal   <= 1'b0;
      matchCnt  <= 3'd0;
      missCnt   <= 3'd0;
    end else begin
      idx_valid <= 1'b0;
      err       <= 1'b0;
      illegal   <= 1'b0;
      if (in_valid) begin
        case (state)
          StHunt: begin
            if (sLegal) begin
              idx      <= sIdx;
              expected <= sNext;
              matchCnt <= 3'd0;
              missCnt  <= 3'd0;
              state    <= StConfirm;
            end else begin
              illegal <= 1'b1;
            end
          end
          StConfirm: begin
            if (!sLegal) begin
              illegal  <= 1'b1;
              matchCnt <= 3'd0;
              expected <= RESET_STATE;
              state    <= StHunt;
            end else if (in_state == expected) begin
              idx      <= sIdx;
              expected <= sNext;
              if (matchCnt + 3'd1 == LockTarget) begin
                state     <= StLocked;
                locked    <= 1'b1;
                idx_valid <= 1'b1;
                matchCnt  <= 3'd0;
                missCnt   <= 3'd0;
              end else begin
                matchCnt <= matchCnt + 3'd1;
              end
            end else begin
              // A legal but unexpected code is the best new seed we have
              err      <= 1'b1;
              idx      <= sIdx;
              expected <= sNext;
              matchCnt <= 3'd0;
            end
          end
          StLocked: begin
            if (in_state == expected) begin
              idx       <= sIdx;
              idx_valid <= 1'b1;
              expected  <= sNext;
              missCnt   <= 3'd0;
            end else begin
              err     <= sLegal;
              illegal <= ~sLegal;
              idx     <= rawToIdx(expected);
              if (missCnt + 3'd1 == LossTarget) begin
                state    <= StHunt;
                locked   <= 1'b0;
                missCnt  <= 3'd0;
                matchCnt <= 3'd0;
                expected <= RESET_STATE;
              end else begin
                missCnt  <= missCnt + 3'd1;
                expected <= nextRaw(expected);
              end
            end
          end
          default: begin
            state <= StHunt;
          end
        endcase
      end
    end
  end

`ifdef SEQ_TRACK_ERRCNT_EN
  // Saturating count of cycles showing an err or illegal pulse
  always_ff @(posedge C or negedge nR) begin
    if (!nR) begin
      err_cnt <= 8'd0;
    end else if ((err || illegal) && (err_cnt != 8'hFF)) begin
      err_cnt <= err_cnt + 8'd1;
    end
  end
`endif

endmodule

// File: tb/tb_seq_track.sv
// tb/tb_seq_track.sv - directed self-checking bench for seq_track (SEQ_TRACK_ERRCNT_EN aware)
module tb_seq_track;

  logic       C;
  logic       nR;
  logic       in_valid;
  logic [3:0] in_state;
  logic [3:0] expected;
  logic [3:0] idx;
  logic       idx_valid;
  logic       locked;
  logic       err;
  logic       illegal;
`ifdef SEQ_TRACK_ERRCNT_EN
  logic [7:0] err_cnt;
`endif

  int errors = 0;
  int checks = 0;

  seq_track #(.LOCK_CNT(3), .LOSS_CNT(2)) dut (
    .C        (C),
    .nR       (nR),
    .in_valid (in_valid),
    .in_state (in_state),
    .expected (expected),
    .idx      (idx),
    .idx_valid(idx_valid),
    .locked   (locked),
    .err      (err),
`ifdef SEQ_TRACK_ERRCNT_EN
    .err_cnt  (err_cnt),
`endif
    .illegal  (illegal)
  );

  initial C = 1'b0;
  always #5 C = ~C;

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] req);
    checks++;
    assert (obs === req) else begin
      errors++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, obs, req);
    end
  endtask

  task automatic samp(input logic v, input logic [3:0] s);
    @(negedge C);
    in_valid = v;
    in_state = s;
    @(posedge C);
    #1;
  endtask

  logic [3:0] runRaw [7];
  logic [3:0] runIdx [7];
  logic [3:0] runNext[7];

  initial begin
    runRaw  = '{4'd4, 4'd14, 4'd9, 4'd0, 4'd3, 4'd5, 4'd10};
    runIdx  = '{4'd4, 4'd5, 4'd6, 4'd7, 4'd8, 4'd9, 4'd0};
    runNext = '{4'd14, 4'd9, 4'd0, 4'd3, 4'd5, 4'd10, 4'd2};

    nR = 1'b0; in_valid = 1'b0; in_state = 4'd0;
    #12;
    chk("rst_expect", 8'(expected), 8'd10);
    chk("rst_idx", 8'(idx), 8'd0);
    chk("rst_locked", 8'(locked), 8'd0);
    chk("rst_pulses", 8'({idx_valid, err, illegal}), 8'd0);
`ifdef SEQ_TRACK_ERRCNT_EN
    chk("rst_errcnt", err_cnt, 8'd0);
`endif
    @(negedge C); nR = 1'b1;

    // Acquire: seed 10 then three matches
    samp(1'b1, 4'd10);
    chk("seed_locked", 8'(locked), 8'd0);
    chk("seed_idxv", 8'(idx_valid), 8'd0);
    chk("seed_expect", 8'(expected), 8'd2);
    samp(1'b1, 4'd2);
    samp(1'b1, 4'd11);
    chk("conf_locked", 8'(locked), 8'd0);
    samp(1'b1, 4'd8);
    chk("lock_locked", 8'(locked), 8'd1);
    chk("lock_idx", 8'(idx), 8'd3);
    chk("lock_idxv", 8'(idx_valid), 8'd1);
    chk("lock_expect", 8'(expected), 8'd4);

    // Locked run including wrap 5 -> 10
    for (int i = 0; i < 7; i++) begin
      samp(1'b1, runRaw[i]);
      chk("run_idxv", 8'(idx_valid), 8'd1);
      chk("run_idx", 8'(idx), 8'(runIdx[i]));
      chk("run_err", 8'(err), 8'd0);
      chk("run_expect", 8'(expected), 8'(runNext[i]));
    end

    // Advance to expect=9
    samp(1'b1, 4'd2); samp(1'b1, 4'd11); samp(1'b1, 4'd8);
    samp(1'b1, 4'd4); samp(1'b1, 4'd14);
    chk("pre9_expect", 8'(expected), 8'd9);
    samp(1'b1, 4'd0);
    chk("miss_err", 8'(err), 8'd1);
    chk("miss_locked", 8'(locked), 8'd1);
    chk("miss_expect", 8'(expected), 8'd0);
    chk("miss_idxv", 8'(idx_valid), 8'd0);
    chk("miss_flyidx", 8'(idx), 8'd6);
    samp(1'b1, 4'd0);
    chk("rematch_err", 8'(err), 8'd0);
    chk("rematch_idx", 8'(idx), 8'd7);
    chk("rematch_idxv", 8'(idx_valid), 8'd1);
    samp(1'b1, 4'd3);
    chk("m3_expect", 8'(expected), 8'd5);
    samp(1'b1, 4'd3);
    chk("m3miss_err", 8'(err), 8'd1);
    chk("m3miss_locked", 8'(locked), 8'd1);
    chk("m3miss_expect", 8'(expected), 8'd10);

    // Back on track to expect=4, then two illegal codes lose lock
    samp(1'b1, 4'd10); samp(1'b1, 4'd2); samp(1'b1, 4'd11); samp(1'b1, 4'd8);
    chk("pre4_expect", 8'(expected), 8'd4);
    samp(1'b1, 4'd12);
    chk("ill1_flags", 8'({err, illegal}), 8'd1);
    chk("ill1_locked", 8'(locked), 8'd1);
    chk("ill1_expect", 8'(expected), 8'd14);
    samp(1'b1, 4'd12);
    chk("ill2_illegal", 8'(illegal), 8'd1);
    chk("ill2_locked", 8'(locked), 8'd0);
    chk("ill2_expect", 8'(expected), 8'd10);

    // CONFIRM re-seed on legal mismatch
    samp(1'b1, 4'd10);
    chk("hseed_expect", 8'(expected), 8'd2);
    samp(1'b1, 4'd11);
    chk("reseed_err", 8'(err), 8'd1);
    chk("reseed_expect", 8'(expected), 8'd8);
    chk("reseed_idx", 8'(idx), 8'd2);
    chk("reseed_locked", 8'(locked), 8'd0);
    samp(1'b1, 4'd8); samp(1'b1, 4'd4);
    chk("relock_pre", 8'(locked), 8'd0);
    samp(1'b1, 4'd14);
    chk("relock_locked", 8'(locked), 8'd1);
    chk("relock_idx", 8'(idx), 8'd5);
    chk("relock_expect", 8'(expected), 8'd9);

    // Idle cycles hold everything
    for (int i = 0; i < 5; i++) begin
      samp(1'b0, 4'd7);
      chk("idle_locked", 8'(locked), 8'd1);
      chk("idle_expect", 8'(expected), 8'd9);
      chk("idle_idx", 8'(idx), 8'd5);
      chk("idle_pulses", 8'({idx_valid, err, illegal}), 8'd0);
    end

    // Asynchronous reset mid-cycle
    @(posedge C); #3;
    nR = 1'b0;
    #1;
    chk("arst_locked", 8'(locked), 8'd0);
    chk("arst_expect", 8'(expected), 8'd10);
    chk("arst_idx", 8'(idx), 8'd0);
    @(negedge C); nR = 1'b1;

`ifdef SEQ_TRACK_ERRCNT_EN
    for (int i = 0; i < 300; i++) samp(1'b1, 4'd13);
    samp(1'b0, 4'd0);
    chk("errcnt_sat", err_cnt, 8'd255);
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
